// File: rtl/l1_stream_pkg.sv
// Shared types and default sizing for the L1 read streamer.
// Contents:
//   L1_DATA_WIDTH / L1_LANE_COUNT / L1_DATA_DEPTH / L1_SKID_DEPTH : default configuration
//   L1_IW            : buffer row index width for the default depth
//   stream_state_e   : streamer FSM state
//   lane_row_t       : one buffer row (LANE_COUNT words, lane 0 first)
//   skid_entry_t     : row plus end-of-transfer marker as held in the skid FIFO
package l1_stream_pkg;

   localparam int L1_DATA_WIDTH = 8;
   localparam int L1_LANE_COUNT = 4;
   localparam int L1_DATA_DEPTH = 64;
   localparam int L1_SKID_DEPTH = 2;
   localparam int L1_IW         = $clog2(L1_DATA_DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } stream_state_e;

   typedef logic [0:L1_LANE_COUNT-1][L1_DATA_WIDTH-1:0] lane_row_t;

   typedef struct packed {
      logic      last;
      lane_row_t row;
   } skid_entry_t;

endpackage

// File: rtl/l1_skid_fifo.sv
// Small circular FIFO holding rows (plus last flag) between the buffer read
// port and the PE array.
// Ports:
//   clk_i, rst_ni        : clock, async active-low reset
//   push_i, push_data_i  : write an entry (allowed at full if pop_i is also set)
//   pop_i                : consume the head entry
//   pop_data_o           : head entry, driven from storage registers only
//   full_o, empty_o      : occupancy flags
//   count_o              : registered occupancy
module l1_skid_fifo #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 33,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o     = (count_q == CW'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign pop_data_o = mem_q[rd_ptr_q];

   // At full, a simultaneous pop frees the head slot, which is also the write slot.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) mem_q[wr_ptr_q] <= push_data_i;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (rst_ni) assert (!(push_i && full_o && !pop_i));
   end
`endif

endmodule

// File: rtl/l1_read_streamer.sv
// Streams a contiguous run of L1 buffer rows into the PE array over
// valid/ready. Issues buffer reads only when no buffer write is active and
// a skid FIFO slot is guaranteed for the returning data.
// Ports:
//   clk_i, rst_ni                     : clock, async active-low reset
//   start_i, base_index_i, row_count_i: transfer request (ignored while busy)
//   busy_o, done_o                    : transfer in progress / one-cycle end pulse
//   buf_rd_en_o, buf_read_index_o     : buffer read request (1-cycle latency)
//   buf_wr_active_i                   : buffer is being written this cycle
//   buf_data_out_i                    : buffer read data
//   out_valid_o, out_ready_i          : PE array handshake
//   out_data_o, out_last_o            : row payload and final-row marker
//
// state  | meaning
// IDLE   | waiting for start; done pulses here after a transfer
// STREAM | issuing reads while rows remain
// DRAIN  | all reads issued; waiting for the last row to be accepted
module l1_read_streamer
   import l1_stream_pkg::*;
#(
   parameter  int DATA_WIDTH = L1_DATA_WIDTH,
   parameter  int LANE_COUNT = L1_LANE_COUNT,
   parameter  int DATA_DEPTH = L1_DATA_DEPTH,
   parameter  int SKID_DEPTH = L1_SKID_DEPTH,
   localparam int IW         = $clog2(DATA_DEPTH)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 start_i,
   input  logic [IW-1:0]                        base_index_i,
   input  logic [IW:0]                          row_count_i,
   output logic                                 busy_o,
   output logic                                 done_o,
   output logic                                 buf_rd_en_o,
   output logic [IW-1:0]                        buf_read_index_o,
   input  logic                                 buf_wr_active_i,
   input  logic [0:LANE_COUNT-1][DATA_WIDTH-1:0] buf_data_out_i,
   output logic                                 out_valid_o,
   input  logic                                 out_ready_i,
   output logic [0:LANE_COUNT-1][DATA_WIDTH-1:0] out_data_o,
   output logic                                 out_last_o
);

   localparam int EW = LANE_COUNT * DATA_WIDTH + 1;
   localparam int CW = $clog2(SKID_DEPTH + 1);

   stream_state_e state_q, state_d;
   logic [IW-1:0] rd_ptr_q, rd_ptr_d;
   logic [IW:0]   remaining_q, remaining_d;
   logic          inflight_q, inflight_last_q;
   logic          done_q, done_d;
   logic          issue, issue_last;

   logic [CW-1:0] fifo_count;
   logic          fifo_full, fifo_empty;
   logic [EW-1:0] fifo_head;
   logic          head_last, pop;
   logic [CW:0]   occupancy;
   logic          credit_ok;

   // A read is only issued if its data is guaranteed a FIFO slot: queued
   // entries plus the one possibly still returning from the buffer.
   assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight_q);
   assign credit_ok = (occupancy < (CW+1)'(SKID_DEPTH)) && !fifo_full;

   assign head_last = fifo_head[EW-1];
   assign pop       = out_valid_o && out_ready_i;

   always_comb begin
      state_d     = state_q;
      rd_ptr_d    = rd_ptr_q;
      remaining_d = remaining_q;
      done_d      = 1'b0;
      issue       = 1'b0;
      issue_last  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               rd_ptr_d    = base_index_i;
               remaining_d = row_count_i;
               if (row_count_i == '0) done_d  = 1'b1;
               else                   state_d = STREAM;
            end
         end
         STREAM: begin
            if ((remaining_q != '0) && !buf_wr_active_i && credit_ok) begin
               issue       = 1'b1;
               issue_last  = (remaining_q == (IW+1)'(1));
               rd_ptr_d    = (rd_ptr_q == IW'(DATA_DEPTH - 1)) ? '0 : rd_ptr_q + IW'(1);
               remaining_d = remaining_q - (IW+1)'(1);
               if (issue_last) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && head_last) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= IDLE;
         rd_ptr_q        <= '0;
         remaining_q     <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         rd_ptr_q        <= rd_ptr_d;
         remaining_q     <= remaining_d;
         inflight_q      <= issue;
         inflight_last_q <= issue_last;
         done_q          <= done_d;
      end
   end

   l1_skid_fifo #(
      .DEPTH (SKID_DEPTH),
      .WIDTH (EW)
   ) u_skid (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (inflight_q),
      .push_data_i ({inflight_last_q, buf_data_out_i}),
      .pop_i       (pop),
      .pop_data_o  (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign busy_o           = (state_q != IDLE);
   assign done_o           = done_q;
   assign buf_rd_en_o      = issue;
   assign buf_read_index_o = rd_ptr_q;
   assign out_valid_o      = !fifo_empty;
   assign out_data_o       = fifo_head[EW-2:0];
   // Stale slots may still carry a last flag once popped; only a valid head counts.
   assign out_last_o       = out_valid_o && head_last;

endmodule

// File: tb/tb_l1_read_streamer.sv
module tb_l1_read_streamer;
   import l1_stream_pkg::*;

   localparam int DD = L1_DATA_DEPTH;
   localparam int SD = L1_SKID_DEPTH;
   localparam int IW = L1_IW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [IW-1:0] base = '0;
   logic [IW:0]   cnt = '0;
   logic          busy, done, rd_en;
   logic [IW-1:0] rd_idx;
   logic          wr_act = 1'b0;
   lane_row_t     buf_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   lane_row_t     out_data;
   logic          out_last;

   always #5 clk = ~clk;

   l1_read_streamer dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .start_i          (start),
      .base_index_i     (base),
      .row_count_i      (cnt),
      .busy_o           (busy),
      .done_o           (done),
      .buf_rd_en_o      (rd_en),
      .buf_read_index_o (rd_idx),
      .buf_wr_active_i  (wr_act),
      .buf_data_out_i   (buf_data),
      .out_valid_o      (out_valid),
      .out_ready_i      (out_ready),
      .out_data_o       (out_data),
      .out_last_o       (out_last)
   );

   // Buffer model: fixed one-cycle read latency, junk on cycles without a read.
   lane_row_t mem [DD];
   always @(posedge clk) buf_data <= rd_en ? mem[rd_idx] : lane_row_t'($urandom);

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: expected read order and delivered rows per transfer.
   int        exp_idx_q [$];
   lane_row_t exp_row_q [$];
   bit        exp_last_q [$];
   int        issue_cyc_q [$];
   bit        mon_en = 0;
   bit        done_due = 0;
   int        outstanding = 0;
   bit        prev_stall = 0;
   lane_row_t prev_data;
   logic      prev_last;

   always @(negedge clk) begin
      if (mon_en) begin
         chk("done_pulse", 64'(done), 64'(done_due));
         done_due = 0;
         if (start && cnt == 0) done_due = 1;
         if (prev_stall) begin
            chk("hold_data", 64'(out_data), 64'(prev_data));
            chk("hold_last", 64'(out_last), 64'(prev_last));
         end
         if (rd_en) begin
            chk("read_during_write", 64'(wr_act), 64'(0));
            if (exp_idx_q.size() == 0) chk("extra_read", 64'(rd_en), 64'(0));
            else begin
               chk("rd_index", 64'(rd_idx), 64'(exp_idx_q.pop_front()));
               issue_cyc_q.push_back(cyc);
            end
            outstanding++;
            chk("outstanding_over_skid", 64'(outstanding > SD), 64'(0));
         end
         if (out_valid && out_ready) begin
            if (exp_row_q.size() == 0) chk("extra_row", 64'(out_valid), 64'(0));
            else begin
               bit l;
               l = exp_last_q.pop_front();
               chk("row_data", 64'(out_data), 64'(exp_row_q.pop_front()));
               chk("row_last", 64'(out_last), 64'(l));
               if (issue_cyc_q.size() != 0)
                  chk("latency_ge2", 64'((cyc - issue_cyc_q.pop_front()) >= 2), 64'(1));
               if (l) done_due = 1;
            end
            outstanding--;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   task automatic clear_model();
      exp_idx_q.delete();
      exp_row_q.delete();
      exp_last_q.delete();
      issue_cyc_q.delete();
      outstanding = 0;
      prev_stall  = 0;
      done_due    = 0;
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_busy"},  64'(busy), 64'(0));
      chk({tag, "_done"},  64'(done), 64'(0));
      chk({tag, "_rd_en"}, 64'(rd_en), 64'(0));
      chk({tag, "_index"}, 64'(rd_idx), 64'(0));
      chk({tag, "_valid"}, 64'(out_valid), 64'(0));
      chk({tag, "_last"},  64'(out_last), 64'(0));
      chk({tag, "_data"},  64'(out_data), 64'(0));
   endtask

   task automatic load_model(input int b, input int n);
      for (int i = 0; i < n; i++) begin
         int idx;
         idx = (b + i) % DD;
         exp_idx_q.push_back(idx);
         exp_row_q.push_back(mem[idx]);
         exp_last_q.push_back(i == n - 1);
      end
   endtask

   // mode 0: ready=1; 1: random ready and writes; 2: ready low cycles 3..12;
   // 3: ready=1, writes active on the first three streaming cycles
   task automatic run_xfer(input int b, input int n, input int mode, output int cycles);
      bit got, saw_busy;
      load_model(b, n);
      @(posedge clk); #1;
      start = 1'b1; base = IW'(b); cnt = (IW+1)'(n); out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cycles = 0; got = 0; saw_busy = 0;
      while (!got && cycles < 600) begin
         case (mode)
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = !(cycles >= 3 && cycles < 13);
            default: out_ready = 1'b1;
         endcase
         wr_act = (mode == 3) ? (cycles < 3) : (mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
         @(negedge clk);
         if (busy) saw_busy = 1;
         if (done) got = 1;
         @(posedge clk); #1;
         cycles++;
      end
      wr_act = 1'b0; out_ready = 1'b1;
      chk("done_seen", 64'(got), 64'(1));
      chk("reads_all_issued", 64'(exp_idx_q.size()), 64'(0));
      chk("rows_all_delivered", 64'(exp_row_q.size()), 64'(0));
      chk("busy_after_done", 64'(busy), 64'(0));
      if (n == 0) chk("busy_zero_count", 64'(saw_busy), 64'(0));
      clear_model();
   endtask

   initial begin
      int c_ref, c_wr, c;
      for (int i = 0; i < DD; i++) mem[i] = lane_row_t'($urandom);
      #2;
      check_outputs_zero("reset");
      #10 rst_n = 1'b1;
      mon_en = 1;

      run_xfer(5, 4, 0, c);
      run_xfer(62, 4, 0, c);
      run_xfer(0, 0, 0, c);
      run_xfer(30, 8, 2, c);
      run_xfer(10, 6, 0, c_ref);
      run_xfer(10, 6, 3, c_wr);
      chk("write_block_plus3", 64'(c_wr), 64'(c_ref + 3));
      run_xfer(7, DD, 1, c);

      // Reset in the middle of a stalled transfer.
      load_model(20, 8);
      @(posedge clk); #1;
      start = 1'b1; base = IW'(20); cnt = (IW+1)'(8); out_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      mon_en = 0;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("async_reset");
      clear_model();
      @(posedge clk); #3;
      rst_n = 1'b1;
      out_ready = 1'b1;
      mon_en = 1;
      repeat (5) @(posedge clk);
      #1;
      chk("post_reset_idle", 64'(busy), 64'(0));
      run_xfer(40, 5, 0, c);

      for (int k = 0; k < 6; k++)
         run_xfer(int'($urandom_range(0, DD - 1)), int'($urandom_range(1, 20)), 1, c);

      mon_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
